// File: rtl/mul2bit_mac.sv
// Multiply-accumulate stage for the 2x2 multiplier product stream: sums N_TERMS
// accepted products into a saturating accumulator behind valid/ready handshakes.
module mul2bit_mac #(
    parameter int ACC_W   = 8,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       prod_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W:0]   sat_sum_s;
    logic             transfer_s;

    // Top bit of the result flags saturation; the low ACC_W bits are the clamped sum.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [3:0] prod);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, prod};
        if (sum[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    // Next accumulator value and handshake qualifier.
    always_comb begin
        sat_sum_s  = sat_add(acc_out, prod_in);
        transfer_s = in_valid & in_ready;
    end

    // Control FSM with registered handshake/status outputs and the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            acc_out   <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= ACC;
                        cnt_r    <= '0;
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACC: begin
                    if (transfer_s) begin
                        acc_out  <= sat_sum_s[ACC_W-1:0];
                        overflow <= overflow | sat_sum_s[ACC_W];
                        cnt_r    <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r   <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul2bit_mac.sv
// Directed self-checking bench for mul2bit_mac: default, narrow-accumulator and
// single-term instances share the input stream, each with its own start.
module tb_mul2bit_mac;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, start_c;
    logic       in_valid, out_ready;
    logic [3:0] prod_in;

    logic       in_ready_a, out_valid_a, busy_a, ovf_a;
    logic [7:0] acc_a;
    logic       in_ready_b, out_valid_b, busy_b, ovf_b;
    logic [4:0] acc_b;
    logic       in_ready_c, out_valid_c, busy_c, ovf_c;
    logic [7:0] acc_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic       v_vec [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] p_vec [7] = '{4'd3, 4'd7, 4'd7, 4'd1, 4'd15, 4'd2, 4'd5};
    logic [7:0] e_vec [7] = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd6, 8'd11};

    always #5 clk = ~clk;

    mul2bit_mac #(.ACC_W(8), .N_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .prod_in(prod_in),
        .in_valid(in_valid), .in_ready(in_ready_a), .acc_out(acc_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
        .overflow(ovf_a)
    );

    mul2bit_mac #(.ACC_W(5), .N_TERMS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .prod_in(prod_in),
        .in_valid(in_valid), .in_ready(in_ready_b), .acc_out(acc_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
        .overflow(ovf_b)
    );

    mul2bit_mac #(.ACC_W(8), .N_TERMS(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .prod_in(prod_in),
        .in_valid(in_valid), .in_ready(in_ready_c), .acc_out(acc_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .busy(busy_c),
        .overflow(ovf_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [3:0] p);
        in_valid = v;
        prod_in  = p;
        step();
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; prod_in = 4'd0;
        #2;
        chk("rst_acc_a", 32'(acc_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_in_ready_a", 32'(in_ready_a), 32'd0);
        chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_acc_b", 32'(acc_b), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready_a), 32'd0);

        // Four products 6,9,2,4 back to back
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("t1_busy", 32'(busy_a), 32'd1);
        chk("t1_in_ready", 32'(in_ready_a), 32'd1);
        chk("t1_acc_clear", 32'(acc_a), 32'd0);
        beat(1'b1, 4'd6); chk("t1_acc1", 32'(acc_a), 32'd6);
        beat(1'b1, 4'd9); chk("t1_acc2", 32'(acc_a), 32'd15);
        chk("t1_no_valid_yet", 32'(out_valid_a), 32'd0);
        beat(1'b1, 4'd2); chk("t1_acc3", 32'(acc_a), 32'd17);
        beat(1'b1, 4'd4);
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid_a), 32'd1);
        chk("t1_acc", 32'(acc_a), 32'd21);
        chk("t1_ovf", 32'(ovf_a), 32'd0);
        chk("t1_in_ready_done", 32'(in_ready_a), 32'd0);
        chk("t1_busy_done", 32'(busy_a), 32'd1);

        // Back-pressure in DONE; start pulse must be ignored
        for (int i = 0; i < 5; i++) begin
            start_a = (i == 2);
            step();
            chk("t4_hold_valid", 32'(out_valid_a), 32'd1);
            chk("t4_hold_acc", 32'(acc_a), 32'd21);
        end
        start_a = 1'b0;
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t4_release_valid", 32'(out_valid_a), 32'd0);
        chk("t4_release_busy", 32'(busy_a), 32'd0);
        chk("t4_acc_held", 32'(acc_a), 32'd21);
        step();
        chk("t4_start_ignored", 32'(in_ready_a), 32'd0);

        // Gapped input stream
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            beat(v_vec[i], p_vec[i]);
            chk("t3_acc", 32'(acc_a), 32'(e_vec[i]));
            chk("t3_out_valid", 32'(out_valid_a), (i == 6) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Asynchronous reset mid-operation, then a fresh run
        start_a = 1'b1; step(); start_a = 1'b0;
        beat(1'b1, 4'd1); beat(1'b1, 4'd1);
        in_valid = 1'b0;
        chk("t5_partial", 32'(acc_a), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_acc", 32'(acc_a), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("t5_rst_busy", 32'(busy_a), 32'd0);
        chk("t5_rst_out_valid", 32'(out_valid_a), 32'd0);
        #2 rst = 1'b0;
        step();
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 4; i++) beat(1'b1, 4'd1);
        in_valid = 1'b0;
        chk("t5_acc", 32'(acc_a), 32'd4);
        chk("t5_out_valid", 32'(out_valid_a), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Saturation with a 5-bit accumulator
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 3; i++) beat(1'b1, 4'd9);
        chk("t2_acc3", 32'(acc_b), 32'd27);
        chk("t2_ovf3", 32'(ovf_b), 32'd0);
        beat(1'b1, 4'd9);
        in_valid = 1'b0;
        chk("t2_acc_sat", 32'(acc_b), 32'd31);
        chk("t2_ovf", 32'(ovf_b), 32'd1);
        chk("t2_out_valid", 32'(out_valid_b), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t2_ovf_sticky", 32'(ovf_b), 32'd1);
        chk("t2_idle_valid", 32'(out_valid_b), 32'd0);
        start_b = 1'b1; step(); start_b = 1'b0;
        chk("t2_restart_acc", 32'(acc_b), 32'd0);
        chk("t2_restart_ovf", 32'(ovf_b), 32'd0);
        step();

        // Single-term instance: result two cycles after start
        start_c = 1'b1; step(); start_c = 1'b0;
        in_valid = 1'b1; prod_in = 4'd9;
        chk("t6_not_yet", 32'(out_valid_c), 32'd0);
        step();
        in_valid = 1'b0;
        chk("t6_out_valid", 32'(out_valid_c), 32'd1);
        chk("t6_acc", 32'(acc_c), 32'd9);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t6_idle", 32'(out_valid_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul2bit_mac.md
Name: mul2bit_mac

Overview:
Sequential multiply-accumulate stage directly downstream of the 2x2 combinational multiplier. It consumes the 4-bit product stream (value range 0..9) through a valid/ready handshake, sums exactly N_TERMS accepted products into a saturating accumulator, and presents the result on a valid/ready output.
Upstream logic drives the multiplier operands. This block only registers and accumulates the product. Used for 2-bit dot products (N_TERMS-element vectors).

Parameters:
ACC_W, 8, accumulator and result width in bits; legal range 4..16.
N_TERMS, 4, number of products summed per operation; legal range 1..255.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a new accumulation; honoured only in IDLE.
prod_in  input  4  product from the 2x2 multiplier, unsigned.
in_valid  input  1  prod_in is valid this cycle.
in_ready  output  1  block accepts prod_in this cycle.
acc_out  output  ACC_W  accumulated result.
out_valid  output  1  acc_out holds a completed result.
out_ready  input  1  downstream consumes the result.
busy  output  1  high in ACC and DONE.
overflow  output  1  sticky per operation; the sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (async assert, any state):
  - State goes to IDLE.
  - acc_out=0, cnt=0, overflow=0.
  - in_ready=0, out_valid=0, busy=0.
  - Release is synchronous to clk; the first active edge after deassert sees IDLE.
- State machine: IDLE, ACC, DONE (binary encoded). Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=0, out_valid=0.
  - acc_out holds the last result.
  - When start=1: clear acc_out, overflow and cnt, then go to ACC on the next edge.
- ACC:
  - in_ready=1, busy=1.
  - A transfer occurs on an edge with in_valid=1 and in_ready=1.
  - On a transfer: acc <= acc + zero-extended prod_in, and cnt <= cnt+1.
  - Saturation: if the true sum exceeds 2^ACC_W-1, acc <= all-ones and overflow <= 1. overflow stays set until the next start or reset.
  - A transfer with cnt==N_TERMS-1 is the last one. Go to DONE on that same edge.
  - Idle cycles (in_valid=0) do not change acc or cnt.
  - start is ignored in ACC.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - acc_out and overflow are stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE. out_valid drops the following cycle.
  - start is ignored in DONE.
- Latency: out_valid rises the cycle after the last accepted product. Minimum operation length is 1 (start) + N_TERMS + 1 cycles.
- Width rules:
  - cnt width is clog2(N_TERMS+1).
  - The internal adder is ACC_W+1 bits wide; its carry-out, or a sum above the all-ones value, triggers saturation.
- prod_in values above 9 cannot occur from the multiplier but are accumulated as-is; there is no checking.
- Reset mid-operation drops the partial sum completely. There is no resume.

Test Plan:
- Reset, start, 4 products 6,9,2,4 with in_valid always high -> out_valid the cycle after the 4th transfer, acc_out=21, overflow=0, busy high from the cycle after start.
- ACC_W=5, products 9,9,9,9 -> saturates at the 4th term; acc_out=31, overflow=1. The next start clears overflow to 0 and acc_out to 0.
- in_valid pattern 1,0,0,1,0,1,1 carrying 3,x,x,1,x,2,5 -> only the 4 valid beats are counted; acc_out=11; cycles with in_valid=0 leave acc unchanged.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and acc_out stay constant and a start pulse is ignored. out_ready=1 -> IDLE the next cycle, out_valid=0.
- Assert rst asynchronously (between edges) after 2 transfers -> outputs go to 0 immediately. After release and start, 4 products 1,1,1,1 give acc_out=4.
- N_TERMS=1, single product 9 -> out_valid exactly 2 cycles after start; acc_out=9.
